// File: rtl/jt49_per_meas.sv
// jt49_per_meas: measures the half-period of a square wave (din) in cen ticks.
// Every din transition publishes the number of cen ticks since the previous one
// on period, with a one-clk valid pulse. Counts beyond the W-bit range saturate
// at all-ones and raise ovf.
// Optional build macro JT49_PER_MEAS_FILT_EN: a transition is accepted only after
// din differs from the accepted level on two consecutive cen samples, which
// rejects one-tick glitches at the cost of one extra cen tick of latency.
module jt49_per_meas #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cen,
    input  logic         din,
    output logic [W-1:0] period,
    output logic         valid,
    output logic         ovf,
    output logic         locked
);

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_t;

    localparam logic [W-1:0] ONE = W'(1);

    state_t         state;
    state_t         next_state;
    logic           din_q;
    logic           edge_det;
    logic [W-1:0]   count;
    logic           sat;

`ifdef JT49_PER_MEAS_FILT_EN
    logic pend;

    // Accepted-level tracker: a new level is taken only after two consecutive
    // differing cen samples; a single differing sample merely arms pend.
    // NOTE: sequential state uses non-blocking (<=) so every register sees the
    // pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q <= 1'b0;
            pend  <= 1'b0;
        end else if (cen) begin
            if (din != din_q) begin
                if (pend) begin
                    din_q <= din;
                    pend  <= 1'b0;
                end else begin
                    pend  <= 1'b1;
                end
            end else begin
                pend <= 1'b0;
            end
        end
    end

    assign edge_det = cen && pend && (din != din_q);
`else
    // Previous cen sample of din; any difference is an edge.
    // NOTE: sequential state uses non-blocking (<=) so every register sees the
    // pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q <= 1'b0;
        end else if (cen) begin
            din_q <= din;
        end
    end

    assign edge_det = cen && (din != din_q);
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: leave IDLE on the first accepted edge, then stay in MEAS.
    // NOTE: next_state is given its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (edge_det) next_state = MEAS;
            MEAS:    next_state = MEAS;
            default: next_state = IDLE;
        endcase
    end

    // Interval counter, saturation flag and published results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            sat    <= 1'b0;
            period <= '0;
            ovf    <= 1'b0;
            valid  <= 1'b0;
            locked <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (cen) begin
                case (state)
                    IDLE: begin
                        // First edge only starts the interval; nothing to publish.
                        if (edge_det) begin
                            count  <= ONE;
                            sat    <= 1'b0;
                            locked <= 1'b1;
                        end
                    end
                    MEAS: begin
                        if (edge_det) begin
                            period <= count;
                            ovf    <= sat;
                            valid  <= 1'b1;
                            count  <= ONE;
                            sat    <= 1'b0;
                        end else if (count == '1) begin
                            // Interval longer than the counter range: hold at
                            // all-ones and remember that it overflowed.
                            sat <= 1'b1;
                        end else begin
                            count <= count + ONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jt49_per_meas.sv
// Self-checking bench for jt49_per_meas: a W=12 and a W=4 instance share the
// same stimulus. A reference model timestamps accepted edges in cen ticks and
// derives the expected period as the tick difference, clipped to the width.
module tb_jt49_per_meas;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cen = 1'b0;
    logic        din = 1'b0;
    logic [11:0] period;
    logic        valid, ovf, locked;
    logic [3:0]  period4;
    logic        valid4, ovf4, locked4;

    jt49_per_meas #(.W(12)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .din(din),
        .period(period), .valid(valid), .ovf(ovf), .locked(locked)
    );

    jt49_per_meas #(.W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .cen(cen), .din(din),
        .period(period4), .valid(valid4), .ovf(ovf4), .locked(locked4)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    longint tick;
    longint last_tick;
    bit     seen;
    bit     lvl;
    bit     pend;
    int     m_period12, m_period4;
    bit     m_ovf12, m_ovf4, m_valid, m_locked;

    task automatic model_reset();
        tick = 0; last_tick = 0; seen = 0; lvl = 0; pend = 0;
        m_period12 = 0; m_period4 = 0; m_ovf12 = 0; m_ovf4 = 0;
        m_valid = 0; m_locked = 0;
    endtask

    task automatic model_step(input bit c, input bit d);
        bit     e;
        longint interval;
        m_valid = 0;
        if (c) begin
`ifdef JT49_PER_MEAS_FILT_EN
            e    = (d != lvl) && pend;
            pend = (d != lvl) && !e;
            if (e) lvl = d;
`else
            e   = (d != lvl);
            lvl = d;
`endif
            if (e) begin
                if (seen) begin
                    interval   = tick - last_tick;
                    m_valid    = 1;
                    m_period12 = (interval > 4095) ? 4095 : int'(interval);
                    m_ovf12    = (interval > 4095);
                    m_period4  = (interval > 15) ? 15 : int'(interval);
                    m_ovf4     = (interval > 15);
                end
                seen      = 1;
                m_locked  = 1;
                last_tick = tick;
            end
            tick++;
        end
    endtask

    // Apply one clk cycle of stimulus (from a negedge) and compare at the next negedge.
    task automatic step(input bit c, input bit d, input bit r = 1'b1);
        cen   = c;
        din   = d;
        rst_n = r;
        if (!r) model_reset();
        else    model_step(c, d);
        @(negedge clk);
        check("period12", 32'(period),  32'(m_period12));
        check("valid12",  32'(valid),   32'(m_valid));
        check("ovf12",    32'(ovf),     32'(m_ovf12));
        check("locked12", 32'(locked),  32'(m_locked));
        check("period4",  32'(period4), 32'(m_period4));
        check("valid4",   32'(valid4),  32'(m_valid));
        check("ovf4",     32'(ovf4),    32'(m_ovf4));
        check("locked4",  32'(locked4), 32'(m_locked));
    endtask

    bit cur;

    task automatic do_reset();
        cur = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("rst_period", 32'(period), 32'd0);
        check("rst_valid",  32'(valid),  32'd0);
        check("rst_ovf",    32'(ovf),    32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        step(1'b0, 1'b0, 1'b1);
    endtask

    // Divider: each half-period holds din for p cen ticks, with gap idle clks after each tick.
    task automatic run_div(input int p, input int halves, input int gap);
        for (int h = 0; h < halves; h++) begin
            cur = ~cur;
            for (int k = 0; k < p; k++) begin
                step(1'b1, cur);
                for (int g = 0; g < gap; g++) step(1'b0, cur);
            end
        end
    endtask

    typedef struct {
        bit          c;
        bit          d;
        bit          exp_valid;
        logic [11:0] exp_period;
        bit          exp_locked;
    } vec_t;

    vec_t tbl [10];

    initial begin
        model_reset();
        cur = 1'b0;
        @(negedge clk);
        do_reset();

`ifndef JT49_PER_MEAS_FILT_EN
        // Hand-computed vectors from a clean reset.
        tbl[0] = '{1'b1, 1'b0, 1'b0, 12'd0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 12'd0, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 12'd0, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 12'd0, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 12'd3, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 12'd3, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 12'd3, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 12'd2, 1'b1};
        tbl[8] = '{1'b1, 1'b0, 1'b1, 12'd1, 1'b1};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 12'd1, 1'b1};
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].c, tbl[i].d);
            check($sformatf("tbl%0d_valid", i),  32'(valid),  32'(tbl[i].exp_valid));
            check($sformatf("tbl%0d_period", i), 32'(period), 32'(tbl[i].exp_period));
            check($sformatf("tbl%0d_locked", i), 32'(locked), 32'(tbl[i].exp_locked));
        end
        do_reset();
`endif

        // Period-5 divider, cen every clk.
        run_div(5, 6, 0);
        check("div5_period", 32'(period), 32'd5);
        check("div5_ovf",    32'(ovf),    32'd0);
        check("div5_locked", 32'(locked), 32'd1);

        // Shortest half-period with cen every third clk.
`ifndef JT49_PER_MEAS_FILT_EN
        run_div(1, 8, 2);
        check("div1_period", 32'(period), 32'd1);
`endif

        // Width-4 saturation: a 20-tick interval, then a 7-tick one.
        do_reset();
        repeat (20) step(1'b1, 1'b1);
        step(1'b1, 1'b0);
`ifdef JT49_PER_MEAS_FILT_EN
        step(1'b1, 1'b0);
`endif
        check("w4_sat_period", 32'(period4), 32'd15);
        check("w4_sat_ovf",    32'(ovf4),    32'd1);
        check("w12_20_period", 32'(period),  32'd20);
        repeat (6) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        check("w4_7_period", 32'(period4), 32'd7);
        check("w4_7_ovf",    32'(ovf4),    32'd0);

        // Reset in the middle of a period-9 stream; din is high at release.
        do_reset();
        run_div(9, 3, 0);
        repeat (4) step(1'b1, cur);
        step(1'b1, cur, 1'b0);
        step(1'b1, cur, 1'b0);
        check("midrst_period", 32'(period), 32'd0);
        check("midrst_locked", 32'(locked), 32'd0);
        check("midrst_valid",  32'(valid),  32'd0);
        cur = 1'b1;
        step(1'b0, cur, 1'b1);
`ifndef JT49_PER_MEAS_FILT_EN
        step(1'b1, cur);
        check("relock_valid",  32'(valid),  32'd0);
        check("relock_locked", 32'(locked), 32'd1);
        repeat (8) step(1'b1, cur);
        cur = 1'b0;
        step(1'b1, cur);
        check("after_rst_valid",  32'(valid),  32'd1);
        check("after_rst_period", 32'(period), 32'd9);
`endif
        run_div(9, 3, 0);
        check("div9_period", 32'(period), 32'd9);

        // Period changed on the fly.
        run_div(10, 4, 0);
        run_div(3, 6, 0);
        check("div3_period", 32'(period), 32'd3);
        check("div3_ovf",    32'(ovf),    32'd0);

        // Width-12 saturation.
        repeat (4200) step(1'b1, cur);
        cur = ~cur;
        step(1'b1, cur);
        step(1'b1, cur);
        check("w12_sat_period", 32'(period), 32'd4095);
        check("w12_sat_ovf",    32'(ovf),    32'd1);
        run_div(4, 3, 0);
        check("w12_after_sat_ovf", 32'(ovf), 32'd0);

`ifdef JT49_PER_MEAS_FILT_EN
        // Period-6 stream with a one-tick glitch inside every half-period.
        for (int h = 0; h < 8; h++) begin
            cur = ~cur;
            for (int k = 0; k < 6; k++) step(1'b1, (k == 3) ? ~cur : cur);
        end
        check("glitch_period", 32'(period), 32'd6);
`endif

        // Randomized cen/din with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 999) == 0) begin
                step(1'b1, cur, 1'b0);
            end else begin
                if ($urandom_range(0, 5) == 0) cur = ~cur;
                step($urandom_range(0, 3) != 0, cur);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jt49_per_meas.md
JT49_PER_MEAS -- requirements
Module: jt49_per_meas

Interface
REQ-001 Parameter W, default 12, SHALL set the width of the measured half-period count.
REQ-002 clk  input  1  SHALL be the single clock; all state is updated on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-004 cen  input  1  SHALL be the clock enable; din sampling and counting occur only on clk edges with cen=1.
REQ-005 din  input  1  SHALL be the square wave under measurement, in the clk domain (e.g. a tone divider output).
REQ-006 period  output  W  SHALL be the last measured count of cen ticks between consecutive din transitions.
REQ-007 valid  output  1  SHALL pulse high for exactly one clk cycle when period is updated.
REQ-008 ovf  output  1  SHALL flag that the published interval exceeded the W-bit range.
REQ-009 locked  output  1  SHALL be high once at least one din transition has been seen since reset.

Function
REQ-010 The block SHALL keep din_q, the din value sampled on the previous cen cycle; an edge is a cen cycle where din != din_q.
REQ-011 The FSM SHALL have two states, IDLE (no edge seen yet) and MEAS (counting since the last edge).
REQ-012 IDLE: the counter SHALL hold; on the first edge, go to MEAS, set count=1 and locked=1, and leave valid low.
REQ-013 MEAS, cen without edge: count SHALL increment by 1, saturating at all-ones and then setting the internal sat flag.
REQ-014 MEAS, cen with edge: period SHALL take count, ovf SHALL take sat, valid SHALL pulse, count SHALL reload to 1, and sat SHALL clear.
REQ-015 Round trip: a divider toggling every P cen ticks (1 <= P <= 2^W-1) SHALL produce period=P on every edge after the first.
REQ-016 valid SHALL assert in the same clk edge that registers the edge-detecting cen sample (1 clk latency from the sampled din change).
REQ-017 With cen=0, valid SHALL be 0 and count, period, ovf, din_q and the FSM SHALL hold.
REQ-018 period and ovf SHALL hold between valid pulses.
REQ-019 Saturated count SHALL report period = all-ones with ovf=1; count SHALL never wrap to 0.

Reset
REQ-020 While rst_n=0: period=0, valid=0, ovf=0, locked=0, count=0, sat=0, din_q=0, FSM=IDLE.
REQ-021 Reset mid-measurement SHALL discard the interval in progress; the first edge after release returns only to MEAS with no valid.
REQ-022 Because din_q resets to 0, a din already at 1 at reset release SHALL be detected as the first edge (IDLE->MEAS, no valid).

Configuration
REQ-023 Macro JT49_PER_MEAS_FILT_EN defined: an edge SHALL be recognised only when din differs from the accepted level on two consecutive cen samples.
REQ-024 With the filter, half-periods of 1 cen tick SHALL be ignored, and edge detection and valid SHALL be delayed by one extra cen tick.
REQ-025 With the filter, steady square waves with half-period >= 2 SHALL still measure P exactly.
REQ-026 Macro undefined: single-sample edge detection per REQ-010, and no filter logic SHALL be present.

Verification
REQ-027 W=12, cen=1 every clk, din from a divider with period 5 -> first edge gives locked=1 and no valid; every later edge gives valid, period=5, ovf=0.
REQ-028 cen every 3rd clk, divider period 1 -> period=1 at each edge; valid one clk wide; outputs hold on cen=0 cycles (filter off).
REQ-029 W=4, din held for 20 cen ticks after lock, then toggled -> period=15, ovf=1; next 7-tick interval -> period=7, ovf=0.
REQ-030 rst_n pulsed low mid-interval of a period-9 stream -> all outputs 0; next edge no valid; following edge period=9.
REQ-031 JT49_PER_MEAS_FILT_EN defined, period-6 stream with injected 1-tick glitches -> glitches ignored, period=6 on each real edge.
REQ-032 Period changed 10->3 on the fly -> one transitional value, then period=3 on every subsequent edge.
